div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider. Sits beside the execute stage as its back-end arithmetic unit.
- Execute supplies the two operands, the signedness flag and a start request.
- The block iterates one quotient bit per cycle and returns a packed {remainder, quotient} result with a ready flag.
- Execute holds its stall request until ready is seen.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request; held high by execute until it has consumed ready_o
- annul_i  input  1  cancel an in-flight or pending divide (pipeline flush)
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; valid only while ready_o=1
- ready_o  output  1  result valid
- busy_o  output  1  high in DIVBYZERO or ON

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0.
  - Reset mid-operation discards the work in progress; no ready is produced.
- States: IDLE, DIVBYZERO, ON, END (2-bit encoding). All outputs are registered.
- IDLE:
  - ready_o=0, result_o=0.
  - On an edge with start_i=1 and annul_i=0, operands are latched.
  - If signed_div_i=1, the magnitudes |opdata1|, |opdata2| are latched, along with the quotient sign (op1[W-1]^op2[W-1]) and the remainder sign (op1[W-1]).
  - opdata2_i==0 -> DIVBYZERO; otherwise -> ON with cnt=0 and partial remainder=0.
- ON:
  - Each edge performs one iteration:
    - shift {rem, dividend} left by 1
    - trial = rem - divisor (W+1 bits)
    - if non-negative, rem=trial and the quotient bit is 1; otherwise the quotient bit is 0
  - cnt increments each iteration. The edge completing iteration WIDTH-1 applies sign correction (negate quotient if quotient sign is set; negate remainder if remainder sign is set), then loads result_o, sets ready_o=1 and moves to END.
  - Latency: ready_o rises WIDTH edges after the accepting edge (32 for the default).
- DIVBYZERO:
  - The next edge loads quotient = all ones and remainder = the original dividend (unmodified opdata1_i, for both signed and unsigned).
  - Sets ready_o=1 and moves to END. Latency is 1 edge.
- Signed overflow: 0x80000000 / -1 needs no special case. The natural magnitude result gives quotient 0x80000000, remainder 0.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign.
- END:
  - ready_o=1 and result_o is held while start_i=1.
  - On an edge with start_i=0 -> IDLE with ready_o=0 and result_o=0.
  - A new request cannot be accepted in the same edge as the exit; the minimum gap is 1 cycle in IDLE.
- annul_i:
  - In DIVBYZERO or ON, annul_i=1 at an edge -> IDLE with ready_o=0 and result_o=0.
  - In IDLE, annul_i suppresses acceptance.
  - In END, annul_i behaves like start_i=0 (-> IDLE).
  - Annul has priority over start and over completion on the same edge.
- Operand inputs are ignored after acceptance; execute may change them freely.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined, in IDLE with divisor != 0 and |dividend| < |divisor| (magnitudes per signedness), the block skips ON.
  - Next edge: quotient=0, remainder=original dividend, ready_o=1, -> END (latency 1).
- Not defined: every non-zero divisor takes the full WIDTH iterations.
- The result values are identical either way; only the latency differs.

Test Plan:
- Unsigned 100/7, start held high: ready_o rises exactly 32 edges after acceptance; result_o = {32'd2, 32'd14}. Drop start_i: ready_o=0 one edge later.
- Signed -7/2 (0xFFFFFFF9, 0x00000002): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Divide by zero, 5/0 (signed and unsigned): ready_o after 1 edge; result_o = {0x00000005, 0xFFFFFFFF}; busy_o high for 1 cycle.
- annul_i pulsed at iteration 10 of 20/3: ready_o never rises, state returns to IDLE. A new 9/4 issued next cycle gives {1, 2} after 32 edges.
- rst asserted at iteration 15: all outputs 0 next edge. Start held through the reset restarts cleanly with 32-edge latency.
- With DIV_EARLY_OUT_EN, 3/10: ready_o after 1 edge, result {3, 0}. Without the macro: same result after 32 edges.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per cycle, packed {remainder, quotient} result.
// Optional DIV_EARLY_OUT_EN: short-circuit |dividend| < |divisor| in a single cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVBYZERO = 2'd1,
    ON        = 2'd2,
    END       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   orig_q, orig_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               early_q, early_d;
  logic [2*WIDTH-1:0] result_d;
  logic               ready_d;
  logic               busy_d;

  // Operand magnitudes as seen in IDLE
  logic [WIDTH-1:0] abs1_c, abs2_c;
  logic             neg1_c, neg2_c;
  logic             early_c;

  assign neg1_c = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2_c = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1_c = neg1_c ? -opdata1_i : opdata1_i;
  assign abs2_c = neg2_c ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_c = (abs1_c < abs2_c);
`else
  assign early_c = 1'b0;
`endif

  // One restoring iteration; quotient bits shift into quo_q as dividend bits leave
  logic [WIDTH:0]   rem_sh_c, trial_c;
  logic             qbit_c;
  logic [WIDTH-1:0] rem_nx_c, quo_nx_c, rem_fix_c, quo_fix_c, zq_fill_c;

  assign rem_sh_c  = {rem_q, quo_q[WIDTH-1]};
  assign trial_c   = rem_sh_c - {1'b0, dvs_q};
  assign qbit_c    = ~trial_c[WIDTH];
  assign rem_nx_c  = qbit_c ? trial_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
  assign quo_nx_c  = {quo_q[WIDTH-2:0], qbit_c};
  assign quo_fix_c = qneg_q ? -quo_nx_c : quo_nx_c;
  assign rem_fix_c = rneg_q ? -rem_nx_c : rem_nx_c;
  assign zq_fill_c = early_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    orig_d   = orig_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    early_d  = early_q;
    result_d = result_o;
    ready_d  = ready_o;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          quo_d   = abs1_c;
          dvs_d   = abs2_c;
          orig_d  = opdata1_i;
          qneg_d  = neg1_c ^ neg2_c;
          rneg_d  = neg1_c;
          rem_d   = '0;
          cnt_d   = '0;
          early_d = 1'b0;
          if (opdata2_i == '0) begin
            state_d = DIVBYZERO;
          end else if (early_c) begin
            early_d = 1'b1;
            state_d = DIVBYZERO;
          end else begin
            state_d = ON;
          end
        end
      end
      DIVBYZERO: begin
        if (annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          result_d = {orig_q, zq_fill_c};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          quo_d = quo_nx_c;
          rem_d = rem_nx_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = {rem_fix_c, quo_fix_c};
            ready_d  = 1'b1;
            state_d  = END;
          end
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DIVBYZERO) || (state_d == ON);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      orig_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      early_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      orig_q   <= orig_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      early_q  <= early_d;
      result_o <= result_d;
      ready_o  <= ready_d;
      busy_o   <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32); honours DIV_EARLY_OUT_EN for early-out latency.
module tb_div_unit;

  localparam int unsigned W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 32;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;
  logic bf;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Called at a negedge just before the accepting edge; ends at a negedge in IDLE
  task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp_res,
                             output logic busy_first);
    int lat;
    lat = -1;
    busy_first = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        busy_first   = busy_o;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (ready_o) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_busy_at_ready"}, 64'(busy_o), 64'd0);
    @(negedge clk);
    check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_result"}, result_o, exp_res);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int lat, input logic [63:0] res);
    logic bfl;
    issue(sgn, a, b);
    wait_result(tag, lat, res, bfl);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("u100_7", 1'b0, 32'd100, 32'd7, 32, {32'd2, 32'd14});
    run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, {32'h0, 32'h8000_0000});
    run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32, {32'd1, 32'hFFFF_FFFD});
    run("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32, {32'd1, 32'h7FFF_FFFC});
    run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32, {32'd0, 32'hFFFF_FFFF});

    // Divide by zero, busy for exactly one cycle
    issue(1'b0, 32'd5, 32'd0);
    wait_result("u5_0", 1, {32'd5, 32'hFFFF_FFFF}, bf);
    check("u5_0_busy", 64'(bf), 64'd1);
    issue(1'b1, 32'd5, 32'd0);
    wait_result("s5_0", 1, {32'd5, 32'hFFFF_FFFF}, bf);
    check("s5_0_busy", 64'(bf), 64'd1);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_result("s_m5_0", 1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, bf);

    // Annul mid-divide
    issue(1'b0, 32'd20, 32'd3);
    repeat (10) @(negedge clk);
    check("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    // Annul in IDLE suppresses acceptance of the next request
    issue(1'b0, 32'd9, 32'd4);
    @(negedge clk);
    check("annul_idle_busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0;
    wait_result("u9_4", 32, {32'd1, 32'd2}, bf);

    // Reset mid-divide with start held through it
    issue(1'b0, 32'd100, 32'd7);
    repeat (16) @(negedge clk);
    check("rst_busy_before", 64'(busy_o), 64'd1);
    rst = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(negedge clk);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    wait_result("u50_5", 32, {32'd0, 32'd10}, bf);

    // Small dividend: early-out latency only when the feature is built in
    run("u3_10", 1'b0, 32'd3, 32'd10, EARLY_LAT, {32'd3, 32'd0});
    run("s_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, EARLY_LAT, {32'hFFFF_FFFD, 32'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
